// File: rtl/errcnt_sched.sv
// rtl/errcnt_sched.sv - queues MAC error/success events and replays them as gapped REC/TEC command pulses
module errcnt_sched #(
    parameter int PEND_W = 3,
    parameter int GAP    = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic ev_rec_inc1,
    input  logic ev_rec_inc8,
    input  logic ev_rec_dec,
    input  logic ev_tec_inc8,
    input  logic ev_tec_dec,
    input  logic flush,
    output logic inconerec,
    output logic incegtrec,
    output logic decrec,
    output logic incegttec,
    output logic dectec,
    output logic busy,
    output logic pend_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        GAP_LOAD  = 3'(GAP - 1);

    state_t rec_state, rec_state_nxt;
    state_t tec_state, tec_state_nxt;
    logic [2:0] rec_gap, rec_gap_nxt;
    logic [2:0] tec_gap, tec_gap_nxt;

    logic [PEND_W-1:0] cnt_rec_i8, cnt_rec_i1, cnt_rec_dec, cnt_tec_i8, cnt_tec_dec;
    logic [PEND_W-1:0] nxt_rec_i8, nxt_rec_i1, nxt_rec_dec, nxt_tec_i8, nxt_tec_dec;

    logic deq_rec_i8, deq_rec_i1, deq_rec_dec, deq_tec_i8, deq_tec_dec;
    logic rec_pulse, tec_pulse;
    logic rec_pend_nxt, tec_pend_nxt;
    logic ovf_any;
    logic busy_nxt;

    // Arrival and dequeue in the same cycle cancel; a full counter drops the arrival.
    function automatic logic [PEND_W-1:0] pend_next(
        input logic [PEND_W-1:0] cnt,
        input logic              ev,
        input logic              deq
    );
        logic [PEND_W-1:0] res;
        res = cnt;
        if (ev && !deq) begin
            if (cnt != PEND_MAX) res = cnt + PEND_ONE;
        end else if (deq && !ev) begin
            res = cnt - PEND_ONE;
        end
        return res;
    endfunction

    function automatic logic pend_drop(
        input logic [PEND_W-1:0] cnt,
        input logic              ev,
        input logic              deq
    );
        return ev && !deq && (cnt == PEND_MAX);
    endfunction

    assign rec_pulse = (rec_state == ST_PULSE);
    assign tec_pulse = (tec_state == ST_PULSE);

    // Fixed priority per channel: inc8 first, then inc1, then dec.
    assign deq_rec_i8  = rec_pulse && (cnt_rec_i8 != PEND_ZERO);
    assign deq_rec_i1  = rec_pulse && (cnt_rec_i8 == PEND_ZERO) && (cnt_rec_i1 != PEND_ZERO);
    assign deq_rec_dec = rec_pulse && (cnt_rec_i8 == PEND_ZERO) && (cnt_rec_i1 == PEND_ZERO)
                         && (cnt_rec_dec != PEND_ZERO);
    assign deq_tec_i8  = tec_pulse && (cnt_tec_i8 != PEND_ZERO);
    assign deq_tec_dec = tec_pulse && (cnt_tec_i8 == PEND_ZERO) && (cnt_tec_dec != PEND_ZERO);

    assign nxt_rec_i8  = pend_next(cnt_rec_i8,  ev_rec_inc8, deq_rec_i8);
    assign nxt_rec_i1  = pend_next(cnt_rec_i1,  ev_rec_inc1, deq_rec_i1);
    assign nxt_rec_dec = pend_next(cnt_rec_dec, ev_rec_dec,  deq_rec_dec);
    assign nxt_tec_i8  = pend_next(cnt_tec_i8,  ev_tec_inc8, deq_tec_i8);
    assign nxt_tec_dec = pend_next(cnt_tec_dec, ev_tec_dec,  deq_tec_dec);

    assign ovf_any = pend_drop(cnt_rec_i8,  ev_rec_inc8, deq_rec_i8)
                   | pend_drop(cnt_rec_i1,  ev_rec_inc1, deq_rec_i1)
                   | pend_drop(cnt_rec_dec, ev_rec_dec,  deq_rec_dec)
                   | pend_drop(cnt_tec_i8,  ev_tec_inc8, deq_tec_i8)
                   | pend_drop(cnt_tec_dec, ev_tec_dec,  deq_tec_dec);

    assign rec_pend_nxt = (nxt_rec_i8 != PEND_ZERO) || (nxt_rec_i1 != PEND_ZERO)
                          || (nxt_rec_dec != PEND_ZERO);
    assign tec_pend_nxt = (nxt_tec_i8 != PEND_ZERO) || (nxt_tec_dec != PEND_ZERO);

    always_comb begin
        rec_state_nxt = rec_state;
        rec_gap_nxt   = rec_gap;
        case (rec_state)
            ST_IDLE: begin
                if (rec_pend_nxt) rec_state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                rec_state_nxt = ST_GAP;
                rec_gap_nxt   = GAP_LOAD;
            end
            ST_GAP: begin
                if (rec_gap == 3'd0) rec_state_nxt = rec_pend_nxt ? ST_PULSE : ST_IDLE;
                else                 rec_gap_nxt   = rec_gap - 3'd1;
            end
            default: rec_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tec_state_nxt = tec_state;
        tec_gap_nxt   = tec_gap;
        case (tec_state)
            ST_IDLE: begin
                if (tec_pend_nxt) tec_state_nxt = ST_PULSE;
            end
            ST_PULSE: begin
                tec_state_nxt = ST_GAP;
                tec_gap_nxt   = GAP_LOAD;
            end
            ST_GAP: begin
                if (tec_gap == 3'd0) tec_state_nxt = tec_pend_nxt ? ST_PULSE : ST_IDLE;
                else                 tec_gap_nxt   = tec_gap - 3'd1;
            end
            default: tec_state_nxt = ST_IDLE;
        endcase
    end

    assign busy_nxt = rec_pend_nxt || tec_pend_nxt
                      || (rec_state_nxt != ST_IDLE) || (tec_state_nxt != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rec_state   <= ST_IDLE;
            tec_state   <= ST_IDLE;
            rec_gap     <= 3'd0;
            tec_gap     <= 3'd0;
            cnt_rec_i8  <= PEND_ZERO;
            cnt_rec_i1  <= PEND_ZERO;
            cnt_rec_dec <= PEND_ZERO;
            cnt_tec_i8  <= PEND_ZERO;
            cnt_tec_dec <= PEND_ZERO;
            inconerec   <= 1'b0;
            incegtrec   <= 1'b0;
            decrec      <= 1'b0;
            incegttec   <= 1'b0;
            dectec      <= 1'b0;
            busy        <= 1'b0;
            pend_ovf    <= 1'b0;
        end else begin
            rec_state   <= rec_state_nxt;
            tec_state   <= tec_state_nxt;
            rec_gap     <= rec_gap_nxt;
            tec_gap     <= tec_gap_nxt;
            cnt_rec_i8  <= nxt_rec_i8;
            cnt_rec_i1  <= nxt_rec_i1;
            cnt_rec_dec <= nxt_rec_dec;
            cnt_tec_i8  <= nxt_tec_i8;
            cnt_tec_dec <= nxt_tec_dec;
            incegtrec   <= deq_rec_i8;
            inconerec   <= deq_rec_i1;
            decrec      <= deq_rec_dec;
            incegttec   <= deq_tec_i8;
            dectec      <= deq_tec_dec;
            busy        <= busy_nxt;
            pend_ovf    <= ovf_any;
        end
    end

endmodule

// File: tb/tb_errcnt_sched.sv
// tb/tb_errcnt_sched.sv - directed self-checking bench for errcnt_sched
module tb_errcnt_sched;

    logic clock = 1'b0;
    logic reset;
    logic ev_rec_inc1, ev_rec_inc8, ev_rec_dec, ev_tec_inc8, ev_tec_dec, flush;

    logic inconerec, incegtrec, decrec, incegttec, dectec, busy, pend_ovf;
    logic inconerec_b, incegtrec_b, decrec_b, incegttec_b, dectec_b, busy_b, pend_ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    errcnt_sched #(.PEND_W(3), .GAP(1)) dut (
        .clock(clock), .reset(reset),
        .ev_rec_inc1(ev_rec_inc1), .ev_rec_inc8(ev_rec_inc8), .ev_rec_dec(ev_rec_dec),
        .ev_tec_inc8(ev_tec_inc8), .ev_tec_dec(ev_tec_dec), .flush(flush),
        .inconerec(inconerec), .incegtrec(incegtrec), .decrec(decrec),
        .incegttec(incegttec), .dectec(dectec), .busy(busy), .pend_ovf(pend_ovf)
    );

    // Long gap lets the TEC inc8 queue fill up within nine events.
    errcnt_sched #(.PEND_W(3), .GAP(7)) dut_b (
        .clock(clock), .reset(reset),
        .ev_rec_inc1(ev_rec_inc1), .ev_rec_inc8(ev_rec_inc8), .ev_rec_dec(ev_rec_dec),
        .ev_tec_inc8(ev_tec_inc8), .ev_tec_dec(ev_tec_dec), .flush(flush),
        .inconerec(inconerec_b), .incegtrec(incegtrec_b), .decrec(decrec_b),
        .incegttec(incegttec_b), .dectec(dectec_b), .busy(busy_b), .pend_ovf(pend_ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_ev();
        ev_rec_inc1 = 1'b0; ev_rec_inc8 = 1'b0; ev_rec_dec = 1'b0;
        ev_tec_inc8 = 1'b0; ev_tec_dec  = 1'b0;
    endtask

    function automatic logic [6:0] out_a();
        return {inconerec, incegtrec, decrec, incegttec, dectec, busy, pend_ovf};
    endfunction

    function automatic logic [6:0] out_b();
        return {inconerec_b, incegtrec_b, decrec_b, incegttec_b, dectec_b, busy_b, pend_ovf_b};
    endfunction

    initial begin
        logic [9:0] seq;
        logic [7:0] s_i8, s_i1, s_dec, s_tdec;
        logic       any;
        int         n_ovf, n_pulse, budget;

        reset = 1'b0;
        flush = 1'b0;
        clear_ev();
        @(negedge clock);

        // Reset held with events toggling
        for (int i = 0; i < 5; i++) begin
            {ev_rec_inc1, ev_rec_inc8, ev_rec_dec, ev_tec_inc8, ev_tec_dec} = 5'($urandom) | 5'b00001;
            tick();
            check("reset_outputs", {18'd0, out_a(), out_b()}, 32'd0);
        end
        clear_ev();
        reset = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any = any | (|out_a()) | (|out_b());
        end
        check("post_reset_idle", any, 0);

        // Single event latency
        ev_rec_inc1 = 1'b1;
        tick();
        clear_ev();
        check("single_k_cmd", inconerec, 0);
        check("single_k_busy", busy, 1);
        tick();
        check("single_k1_cmd", inconerec, 1);
        tick();
        check("single_k2_cmd", inconerec, 0);
        check("single_k2_busy", busy, 0);

        // Burst of three inc1 events
        for (int i = 0; i < 10; i++) begin
            ev_rec_inc1 = (i < 3);
            tick();
            seq[i] = inconerec;
        end
        clear_ev();
        check("burst_seq", seq, 10'b00_0010_1010);
        check("burst_busy", busy, 0);

        // Priority within REC, TEC independent
        for (int i = 0; i < 8; i++) begin
            ev_rec_dec = (i == 0); ev_rec_inc1 = (i == 0); ev_rec_inc8 = (i == 0);
            ev_tec_dec = (i == 0);
            tick();
            s_i8[i] = incegtrec; s_i1[i] = inconerec; s_dec[i] = decrec; s_tdec[i] = dectec;
        end
        clear_ev();
        check("prio_incegtrec", s_i8, 8'b0000_0010);
        check("prio_inconerec", s_i1, 8'b0000_1000);
        check("prio_decrec", s_dec, 8'b0010_0000);
        check("prio_dectec", s_tdec, 8'b0000_0010);
        check("prio_busy", busy, 0);

        // Overflow on the long-gap instance
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ovf_pre_idle", busy_b, 0);
        n_ovf = 0;
        n_pulse = 0;
        for (int i = 0; i < 9; i++) begin
            ev_tec_inc8 = 1'b1;
            tick();
            n_ovf += int'(pend_ovf_b);
            n_pulse += int'(incegttec_b);
            if (i == 8) check("ovf_pulse_at_9th", pend_ovf_b, 1);
        end
        clear_ev();
        budget = 0;
        while (busy_b && budget < 200) begin
            tick();
            n_ovf += int'(pend_ovf_b);
            n_pulse += int'(incegttec_b);
            budget++;
        end
        check("ovf_drain_timeout", busy_b, 0);
        check("ovf_count", n_ovf, 1);
        check("ovf_pulses", n_pulse, 8);
        check("ovf_sum", n_pulse + n_ovf, 9);

        // Flush during the first pulse
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ev_rec_inc8 = 1'b1; ev_rec_inc1 = 1'b1; ev_rec_dec = 1'b1;
        tick();
        clear_ev();
        ev_rec_inc1 = 1'b1;
        tick();
        clear_ev();
        check("flush_first_pulse", incegtrec, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_outputs", out_a(), 7'd0);
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any = any | inconerec | incegtrec | decrec | busy;
        end
        check("flush_no_more", any, 0);

        // Events coincident with flush are discarded
        flush = 1'b1;
        ev_tec_dec = 1'b1;
        tick();
        flush = 1'b0;
        clear_ev();
        any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any = any | dectec | busy;
        end
        check("flush_discard", any, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
